// File: rtl/data_mem_ctrl.sv
// Data-memory access controller: single outstanding load/store between core and sync RAM.
// Optional misaligned-access error reporting under `DATA_MEM_MISALIGN_EXC_EN.
module data_mem_ctrl #(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clka,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic              unsigned_ld,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              ack,
  output logic              stall,
  output logic              addr_err,
  output logic              ram_ena,
  output logic [3:0]        ram_wea,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_dina,
  input  logic [31:0]       ram_douta
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned LANES  = 4;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  typedef struct packed {
    logic       we;
    logic [1:0] size;
    logic       uns;
    logic [1:0] lane;
    logic       err;
  } req_t;

  state_t              state, state_nxt;
  req_t                cur, cur_nxt;
  logic                ack_nxt, err_nxt, ena_nxt;
  logic [LANES-1:0]    wea_nxt, mask_c;
  logic [ADDR_W-1:0]   addr_nxt;
  logic [DATA_W-1:0]   dina_nxt, repl_c, fmt_c, hold, hold_nxt;
  logic [7:0]          byte_c;
  logic [15:0]         half_c;
  logic                misalign_c;
  logic                unused_hi;

  assign unused_hi = ^addr[31:ADDR_W+2];

`ifdef DATA_MEM_MISALIGN_EXC_EN
  assign misalign_c = (size == 2'b01 && addr[0]) || (size[1] && addr[1:0] != 2'b00);
`else
  assign misalign_c = 1'b0;
`endif

  // Store lane mask and replicated write data from the incoming request
  always_comb begin
    mask_c = 4'b1111;
    repl_c = wdata;
    case (size)
      2'b00: begin
        mask_c = 4'b0001 << addr[1:0];
        repl_c = {4{wdata[7:0]}};
      end
      2'b01: begin
        mask_c = addr[1] ? 4'b1100 : 4'b0011;
        repl_c = {2{wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // Load lane selection and extension from the registered request
  always_comb begin
    case (cur.lane)
      2'd0:    byte_c = ram_douta[7:0];
      2'd1:    byte_c = ram_douta[15:8];
      2'd2:    byte_c = ram_douta[23:16];
      default: byte_c = ram_douta[31:24];
    endcase
    half_c = cur.lane[1] ? ram_douta[31:16] : ram_douta[15:0];
    case (cur.size)
      2'b00:   fmt_c = {{24{~cur.uns & byte_c[7]}}, byte_c};
      2'b01:   fmt_c = {{16{~cur.uns & half_c[15]}}, half_c};
      default: fmt_c = ram_douta;
    endcase
  end

  // Next-state and next-output logic
  always_comb begin
    state_nxt = state;
    cur_nxt   = cur;
    ack_nxt   = 1'b0;
    err_nxt   = 1'b0;
    ena_nxt   = 1'b0;
    wea_nxt   = '0;
    addr_nxt  = ram_addr;
    dina_nxt  = ram_dina;
    hold_nxt  = hold;
    case (state)
      IDLE: begin
        if (req) begin
          cur_nxt.we   = we;
          cur_nxt.size = size;
          cur_nxt.uns  = unsigned_ld;
          cur_nxt.lane = addr[1:0];
          cur_nxt.err  = misalign_c;
          if (misalign_c) begin
            state_nxt = RESP;
            ack_nxt   = 1'b1;
            err_nxt   = 1'b1;
          end else begin
            state_nxt = ACCESS;
            ena_nxt   = 1'b1;
            wea_nxt   = we ? mask_c : 4'b0000;
            addr_nxt  = addr[ADDR_W+1:2];
            if (we) dina_nxt = repl_c;
          end
        end
      end
      ACCESS: begin
        state_nxt = RESP;
        ack_nxt   = 1'b1;
      end
      RESP: begin
        state_nxt = IDLE;
        if (!cur.we && !cur.err) hold_nxt = fmt_c;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clka or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cur      <= '0;
      ack      <= 1'b0;
      addr_err <= 1'b0;
      ram_ena  <= 1'b0;
      ram_wea  <= '0;
      ram_addr <= '0;
      ram_dina <= '0;
      hold     <= '0;
    end else begin
      state    <= state_nxt;
      cur      <= cur_nxt;
      ack      <= ack_nxt;
      addr_err <= err_nxt;
      ram_ena  <= ena_nxt;
      ram_wea  <= wea_nxt;
      ram_addr <= addr_nxt;
      ram_dina <= dina_nxt;
      hold     <= hold_nxt;
    end
  end

  // Live formatted data only during a successful load response
  always_comb begin
    rdata = hold;
    if (state == RESP) begin
      if (cur.err)     rdata = '0;
      else if (!cur.we) rdata = fmt_c;
    end
  end

  assign stall = req & ~ack;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed self-checking bench for data_mem_ctrl with a behavioural byte-enabled sync RAM.
module tb_data_mem_ctrl;

  logic        clka, rst, req, we, unsigned_ld;
  logic [1:0]  size;
  logic [31:0] addr, wdata, rdata, ram_dina, ram_douta;
  logic        ack, stall, addr_err, ram_ena;
  logic [3:0]  ram_wea;
  logic [9:0]  ram_addr;

  int total = 0;
  int bad   = 0;

  logic        obs_ena, obs_ack, obs_err;
  logic [3:0]  obs_wea;
  logic [9:0]  obs_addr;
  logic [31:0] obs_dina, obs_rdata;
  int          obs_cyc;

  logic [31:0] mem [0:1023];

  data_mem_ctrl #(.ADDR_W(10)) dut (
    .clka(clka), .rst(rst), .req(req), .we(we), .size(size),
    .unsigned_ld(unsigned_ld), .addr(addr), .wdata(wdata), .rdata(rdata),
    .ack(ack), .stall(stall), .addr_err(addr_err), .ram_ena(ram_ena),
    .ram_wea(ram_wea), .ram_addr(ram_addr), .ram_dina(ram_dina),
    .ram_douta(ram_douta)
  );

  always #5 clka = ~clka;

  always @(posedge clka) begin
    if (ram_ena) begin
      for (int i = 0; i < 4; i++)
        if (ram_wea[i]) mem[ram_addr][8*i +: 8] <= ram_dina[8*i +: 8];
      ram_douta <= mem[ram_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One request with req held until ack; records what the RAM port and core side saw
  task automatic access(input logic w, input logic [1:0] sz, input logic u,
                        input logic [31:0] a, input logic [31:0] d);
    @(negedge clka);
    req = 1'b1; we = w; size = sz; unsigned_ld = u; addr = a; wdata = d;
    obs_ena = 1'b0; obs_wea = '0; obs_ack = 1'b0; obs_cyc = 0;
    for (int i = 1; i <= 6 && !obs_ack; i++) begin
      @(negedge clka);
      if (ram_ena) begin
        obs_ena = 1'b1; obs_wea = ram_wea; obs_addr = ram_addr; obs_dina = ram_dina;
      end
      if (ack) begin
        obs_ack = 1'b1; obs_cyc = i; obs_rdata = rdata; obs_err = addr_err;
      end
    end
    req = 1'b0;
    if (!obs_ack) chk("ack_timeout", 32'd0, 32'd1);
  endtask

  logic [5:0]  stall_v, ack_v;
  logic [31:0] rd_v [0:5];
  logic        ack_seen;

  initial begin
    clka = 1'b0; rst = 1'b0; req = 1'b0; we = 1'b0; size = 2'b00;
    unsigned_ld = 1'b0; addr = '0; wdata = '0;
    #2;
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_err", 32'(addr_err), 32'd0);
    chk("rst_ena", 32'(ram_ena), 32'd0);
    chk("rst_wea", 32'(ram_wea), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_raddr", 32'(ram_addr), 32'd0);
    chk("rst_dina", ram_dina, 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    @(negedge clka); rst = 1'b1;

    access(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
    chk("sw_lat", 32'(obs_cyc), 32'd2);
    chk("sw_wea", 32'(obs_wea), 32'hF);
    chk("sw_addr", 32'(obs_addr), 32'd4);
    chk("sw_dina", obs_dina, 32'hDEADBEEF);
    chk("sw_rdata", obs_rdata, 32'd0);

    access(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    chk("lw_lat", 32'(obs_cyc), 32'd2);
    chk("lw_wea", 32'(obs_wea), 32'h0);
    chk("lw_rdata", obs_rdata, 32'hDEADBEEF);

    access(1'b1, 2'b00, 1'b0, 32'h13, 32'h000000AB);
    chk("sb_wea", 32'(obs_wea), 32'h8);
    chk("sb_dina", obs_dina, 32'hABABABAB);
    chk("sb_rdata_hold", obs_rdata, 32'hDEADBEEF);

    access(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    chk("lw_after_sb", obs_rdata, 32'hABADBEEF);

    access(1'b1, 2'b10, 1'b0, 32'h20, 32'h80017F80);
    access(1'b0, 2'b00, 1'b0, 32'h20, 32'h0);
    chk("lb", obs_rdata, 32'hFFFFFF80);
    access(1'b0, 2'b00, 1'b1, 32'h20, 32'h0);
    chk("lbu", obs_rdata, 32'h00000080);
    access(1'b0, 2'b01, 1'b0, 32'h22, 32'h0);
    chk("lh", obs_rdata, 32'hFFFF8001);
    access(1'b0, 2'b01, 1'b1, 32'h22, 32'h0);
    chk("lhu", obs_rdata, 32'h00008001);

    access(1'b1, 2'b01, 1'b0, 32'h22, 32'h00001234);
    chk("sh_wea", 32'(obs_wea), 32'hC);
    chk("sh_dina", obs_dina, 32'h12341234);
    access(1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
    chk("lw_after_sh", obs_rdata, 32'h12347F80);

    access(1'b0, 2'b10, 1'b0, 32'h12, 32'h0);
`ifdef DATA_MEM_MISALIGN_EXC_EN
    chk("mis_lat", 32'(obs_cyc), 32'd1);
    chk("mis_err", 32'(obs_err), 32'd1);
    chk("mis_ena", 32'(obs_ena), 32'd0);
    chk("mis_rdata", obs_rdata, 32'd0);
    @(negedge clka);
    chk("mis_hold", rdata, 32'h12347F80);
`else
    chk("mis_lat", 32'(obs_cyc), 32'd2);
    chk("mis_err", 32'(obs_err), 32'd0);
    chk("mis_addr", 32'(obs_addr), 32'd4);
    chk("mis_rdata", obs_rdata, 32'hABADBEEF);
`endif

    // Back-to-back loads with req held high across both
    @(negedge clka);
    req = 1'b1; we = 1'b0; size = 2'b10; unsigned_ld = 1'b0; addr = 32'h10;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) @(negedge clka);
      #1;
      stall_v[k] = stall;
      ack_v[k]   = ack;
      rd_v[k]    = rdata;
      if (k == 2) addr = 32'h20;
    end
    req = 1'b0;
    chk("b2b_stall", 32'(stall_v), 32'h1B);
    chk("b2b_ack", 32'(ack_v), 32'h24);
    chk("b2b_rd0", rd_v[2], 32'hABADBEEF);
    chk("b2b_hold3", rd_v[3], 32'hABADBEEF);
    chk("b2b_hold4", rd_v[4], 32'hABADBEEF);
    chk("b2b_rd1", rd_v[5], 32'h12347F80);

    // Reset while a store is in ACCESS
    @(negedge clka);
    req = 1'b1; we = 1'b1; size = 2'b10; addr = 32'h10; wdata = 32'h11111111;
    @(negedge clka);
    chk("mid_pre_ena", 32'(ram_ena), 32'd1);
    #1 rst = 1'b0;
    #1;
    chk("mid_ena", 32'(ram_ena), 32'd0);
    chk("mid_wea", 32'(ram_wea), 32'd0);
    chk("mid_ack", 32'(ack), 32'd0);
    chk("mid_rdata", rdata, 32'd0);
    chk("mid_raddr", 32'(ram_addr), 32'd0);
    req = 1'b0;
    @(negedge clka); rst = 1'b1;
    ack_seen = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clka);
      ack_seen = ack_seen | ack;
    end
    chk("mid_no_ack", 32'(ack_seen), 32'd0);
    access(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    chk("mid_old_data", obs_rdata, 32'hABADBEEF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/data_mem_ctrl.md
# data_mem_ctrl

Data-memory access controller between the MIPS core's load/store path and the synchronous data RAM. It accepts one request at a time from the core over a req/ack handshake and asserts a stall while the request is outstanding. It generates per-byte write enables and replicated write data for sb/sh/sw, and returns sign- or zero-extended load data for lb/lbu/lh/lhu/lw. It absorbs the RAM's one-cycle read latency.

## Interface
- ADDR_W, default 10: width of the RAM word address; `ram_addr = addr[ADDR_W+1:2]`.
- clka  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- req  in  1  core request valid; held stable with its qualifiers until `ack`.
- we  in  1  1 = store, 0 = load.
- size  in  2  00 byte, 01 halfword, 10 word, 11 reserved (treated as word).
- unsigned_ld  in  1  1 = zero-extend load, 0 = sign-extend; ignored for word and stores.
- addr  in  32  byte address.
- wdata  in  32  store data, right-aligned.
- rdata  out  32  extended load data.
- ack  out  1  one-cycle completion pulse.
- stall  out  1  `req & ~ack`, combinational; freezes the core PC.
- addr_err  out  1  misaligned-access flag, valid with `ack`. Constant 0 without the macro.
- ram_ena  out  1  RAM enable.
- ram_wea  out  4  RAM byte write enables; bit i covers `ram_dina[8i+7:8i]`.
- ram_addr  out  ADDR_W  RAM word address.
- ram_dina  out  32  RAM write data.
- ram_douta  in  32  RAM read data; valid one cycle after the enabling edge.

## Operation
- FSM states are IDLE, ACCESS and RESP. Reset state is IDLE.
- **IDLE**
  - On `req`, register `we`, `size`, `unsigned_ld`, `addr` and `wdata`, then go to ACCESS.
  - With the macro enabled and the request misaligned, go directly to RESP instead and issue no RAM access.
- **ACCESS**
  - `ram_ena = 1`.
  - `ram_addr` comes from the registered address.
  - For stores, `ram_wea` = lane mask; for loads, `ram_wea = 0`.
  - Always go to RESP.
- **RESP**
  - `ack = 1`.
  - For loads, `rdata` is formatted combinationally from `ram_douta` and captured into a hold register at the end of the cycle.
  - Go to IDLE.
- Lane mask (little-endian, lane = `addr[1:0]`):
  - byte: `4'b0001 << addr[1:0]`.
  - half: `addr[1]` ? 1100 : 0011.
  - word: 1111.
- Write data replication:
  - byte: `{4{wdata[7:0]}}`.
  - half: `{2{wdata[15:0]}}`.
  - word: `wdata`.
- Load formatting:
  - Select the byte or half at the lane, then extend per `unsigned_ld`.
  - Word loads pass through unmodified.
- `rdata` outside RESP:
  - shows the hold register (last load result);
  - is unchanged by stores and by error acks;
  - is 0 during an error ack.
- `req` still high during RESP belongs to the completing request. `req` sampled in the following IDLE cycle is a new request.
- Outputs while in IDLE: `ram_ena = 0`, `ram_wea = 0`; `ram_addr` and `ram_dina` hold their last values.

## Timing
- Outputs at reset:
  - `ack`, `addr_err`, `ram_ena`: 0.
  - `ram_wea`: 0000.
  - `rdata`, `ram_addr`, `ram_dina`: 0.
  - Reset takes effect asynchronously.
- Normal access:
  - `req` sampled at edge N.
  - ACCESS occupies cycle N+1.
  - `ack` is high in cycle N+2.
  - Throughput is 3 cycles per access. No pipelining.
- Misaligned access with the macro enabled: `ack` and `addr_err` are high in cycle N+1, with no `ram_ena` pulse.
- Reset mid-operation:
  - Forces IDLE and zeroes all outputs immediately.
  - A store in ACCESS whose edge has not yet occurred is dropped.
  - No `ack` is issued for an aborted request.
- Simultaneous `req` deassertion and `ack` is legal. Deasserting `req` before `ack` is illegal; the behaviour in that case is undefined.

## Configuration
- `DATA_MEM_MISALIGN_EXC_EN`
  - **Defined:** halfword accesses with `addr[0] = 1` and word accesses with `addr[1:0] != 0` complete with `addr_err = 1` and perform no RAM write or read.
  - **Undefined:** `addr_err` is tied to 0, and the unused low address bits are ignored:
    - halfword accesses use `addr[1]` only;
    - word accesses ignore `addr[1:0]`.

## Test plan
- **Word store/load:** sw `0xDEADBEEF` @`0x10`, then lw @`0x10` → each store has `ram_wea = 1111`, `ram_addr = 4`, and `ack` 2 cycles after `req`; the load returns `rdata = 0xDEADBEEF` on `ack`.
- **Byte store:** sb `0x000000AB` @`0x13` → `ram_wea = 1000`, `ram_dina = 0xABABABAB`. A following lw @`0x10` returns `0xABADBEEF` over the prior word.
- **Sign vs zero extension:** word `0x80017F80` @`0x20`:
  - lb @`0x20` → `0xFFFFFF80`;
  - lbu @`0x20` → `0x00000080`;
  - lh @`0x22` → `0xFFFF8001`;
  - lhu @`0x22` → `0x00008001`.
- **Misaligned access:** lw @`0x12` with the macro → `ack` + `addr_err` in cycle N+1, `ram_ena` never high, `rdata = 0`. Without the macro → normal read of word address 4, `addr_err = 0`.
- **Stall/handshake:** two back-to-back loads with `req` held high → `stall` is 1 for 2 cycles of each, `ack` pulses 3 cycles apart, and `rdata` holds the first result between the acks.
- **Reset mid-access:** assert `rst` low during ACCESS of an sw → `ram_ena`/`ram_wea` drop immediately, no `ack`, FSM restarts from IDLE, and a subsequent lw returns the old RAM contents.
